// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16 x 8 FIFO controller and its pointer registers.
package fifo_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int AF_THRESH = 14;
    localparam int AE_THRESH = 2;

    // Wrap-bit pointer: MSB toggles on every pass through the array, low bits address it.
    typedef logic [ADDR_W:0] ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: clears on reset or clear, otherwise advances by one on inc.
// Natural overflow of the PW-bit register gives the modulo 2**PW wrap and the wrap-bit toggle.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int PW = ADDR_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] ONE = 1;

    logic [PW-1:0] r_ptr;

    // Pointer register: reset and clear take priority over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + ONE;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, status and error controller for the FIFO storage array.
// Handshake: fifo_we = wr_req & ~full and rd_ack = rd_req & ~empty, both combinational
// from the requests and registered state only; a request is accepted in the cycle its
// strobe is high and its effect appears on pointers, count and flags after the next edge.
module fifo_ctrl #(
    parameter int ADDR_W    = fifo_pkg::ADDR_W,
    parameter int AF_THRESH = fifo_pkg::AF_THRESH,
    parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_req,
    input  logic            rd_req,
    input  logic            flush,
    input  logic            clr_err,
    output logic            fifo_we,
    output logic            rd_ack,
    output logic [ADDR_W:0] wptr,
    output logic [ADDR_W:0] rptr,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [ADDR_W:0] ONE  = 1;
    localparam logic [ADDR_W:0] AF_T = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_T = AE_THRESH[ADDR_W:0];

    logic [ADDR_W:0] w_wptr;
    logic [ADDR_W:0] w_rptr;
    logic            w_full;
    logic            w_empty;
    logic            w_we;
    logic            w_ack;
    logic            w_ovf_evt;
    logic            w_unf_evt;

    logic [ADDR_W:0] r_count;
    logic            r_overflow;
    logic            r_underflow;

    // A flush clears both pointers, so an accept strobe during flush never advances them.
    fifo_ptr #(.PW(ADDR_W + 1)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (w_we),
        .ptr   (w_wptr)
    );

    fifo_ptr #(.PW(ADDR_W + 1)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (w_ack),
        .ptr   (w_rptr)
    );

    // Status and accept decode from registered pointers; no request feeds a flag.
    always_comb begin
        w_full    = (w_wptr[ADDR_W] != w_rptr[ADDR_W]) &&
                    (w_wptr[ADDR_W-1:0] == w_rptr[ADDR_W-1:0]);
        w_empty   = (w_wptr == w_rptr);
        w_we      = wr_req & ~w_full;
        w_ack     = rd_req & ~w_empty;
        // Rejected requests are errors, except while a flush discards all requests.
        w_ovf_evt = wr_req & w_full  & ~flush;
        w_unf_evt = rd_req & w_empty & ~flush;
    end

    // Fill level: +1 on write only, -1 on read only, held on both or neither.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else begin
            case ({w_we, w_ack})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors: a new error in the same cycle as clr_err wins; flush leaves them as they are.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!flush) begin
            r_overflow  <= (r_overflow  & ~clr_err) | w_ovf_evt;
            r_underflow <= (r_underflow & ~clr_err) | w_unf_evt;
        end
    end

    assign fifo_we      = w_we;
    assign rd_ack       = w_ack;
    assign wptr         = w_wptr;
    assign rptr         = w_rptr;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_T);
    assign almost_empty = (r_count <= AE_T);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer, status and error controller for the team's 16 × 8 `memory_array` FIFO storage. It accepts write and read requests, produces the write enable and the 5-bit wrap-bit pointers that address the array, and tracks the fill level. It raises full/empty/almost flags and sticky overflow/underflow errors. It sits between the producer/consumer logic and `memory_array` inside the FIFO top level.

## Interface
- `ADDR_W`, 4: array address width. Depth = 2**ADDR_W. Pointers are ADDR_W+1 bits.
- `AF_THRESH`, 14: `almost_full` asserts when count ≥ AF_THRESH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ AE_THRESH.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_req`  in  1  producer requests a write this cycle.
- `rd_req`  in  1  consumer requests a read this cycle.
- `flush`  in  1  synchronous empty of the FIFO.
- `clr_err`  in  1  clears the sticky error flags.
- `fifo_we`  out  1  write enable to the array, equal to `wr_req & ~full`.
- `rd_ack`  out  1  read accepted, equal to `rd_req & ~empty`. The consumer samples array `data_out` in this cycle.
- `wptr`  out  ADDR_W+1  write pointer. MSB is the wrap bit; the low bits address the array.
- `rptr`  out  ADDR_W+1  read pointer, same format as `wptr`.
- `count`  out  ADDR_W+1  fill level, 0..2**ADDR_W.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Reset values: `wptr`=0, `rptr`=0, `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0.
- Priority at each edge: `rst` > `flush` > requests.
- `flush`:
  - pointers and `count` go to 0;
  - requests in the same cycle are ignored and do not set the error flags;
  - `overflow` and `underflow` keep their values.
- Write accept (`fifo_we`=1): `wptr` increments modulo 2**(ADDR_W+1).
- Read accept (`rd_ack`=1): `rptr` increments modulo 2**(ADDR_W+1).
- `count` update:
  - +1 on write only;
  - −1 on read only;
  - unchanged when both or neither are accepted.
- Flag decode:
  - `full` = (wptr[ADDR_W] ≠ rptr[ADDR_W]) and equal low bits;
  - `empty` = (wptr == rptr).
- Almost flags decode from registered `count` against the thresholds.
- Boundary conditions:
  - Write while full is rejected even if a read occurs in the same cycle. `overflow` is set.
  - Read while empty is rejected even if a write occurs in the same cycle. `underflow` is set.
  - Read and write both accepted at a non-boundary level: both pointers advance and `count` holds.
  - Wrap: the pointer going 31→0 toggles the wrap bit. The flags must stay correct across any number of wraps.
- Errors:
  - `clr_err` clears both sticky flags at the edge.
  - If a new error occurs in the same cycle as `clr_err`, the flag stays set (set wins).

## Timing
- `fifo_we` and `rd_ack` are combinational from the requests and the registered flags. There is no path from the requests to the flags within the same cycle.
- Pointers, `count` and all flags are registered or decoded from registered state. They reflect an accepted request one edge after it.
- Array read data is valid in the same cycle as `rd_ack`, because the array read is combinational on `rptr`.
- A write accepted at edge N is readable from edge N+1: `empty` deasserts after edge N.
- Reset mid-operation returns every output to its reset value after the reset edge, regardless of the requests present.

## Structure
- Shared package `fifo_pkg` holds:
  - `ADDR_W` (4), `DATA_W` (8), `AF_THRESH`/`AE_THRESH` defaults;
  - a `ptr_t` typedef (ADDR_W+1 bits).
- One sub-module `fifo_ptr`: a wrap-bit pointer register with `clk`, `rst`, `clear`, `inc`, output `ptr`. It is instanced twice, once for write and once for read.
- Flag decode, count and error logic live in `fifo_ctrl`.

## Test plan
- Reset, then 16 writes with no reads. Each write gives `fifo_we`=1. `count` steps 1..16, `almost_full` rises at count 14, `full`=1 after write 16, `wptr`=5'b10000, `rptr`=0.
- From full, `wr_req`=1 and `rd_req`=1 in the same cycle. Required: `fifo_we`=0, `rd_ack`=1, `overflow`=1, count=15, `rptr`=1.
- From empty, `rd_req`=1 and `wr_req`=1 in the same cycle. Required: `rd_ack`=0, `fifo_we`=1, `underflow`=1, count=1. Then assert `clr_err`: both error flags return to 0.
- Fill to 8, then 40 cycles with both requests high. Required: count held at 8, pointers wrap past 31 correctly, `full` and `empty` stay 0 throughout.
- At count 10 with `overflow`=1, assert `flush` together with `wr_req`. Required: after the edge `wptr`=`rptr`=0, count=0, `empty`=1, `overflow` still 1.
- Assert `rst` while `wr_req` and `rd_req` are high at count 5. Required: all outputs at their reset values after the edge.
